// File: rtl/tag_req_gen.sv
// -----------------------------------------------------------------------------
// tag_req_gen
// Turns block commands into tag requests toward a tag allocator. Each accepted
// command raises tag_req until the allocator grants a tag. The grant is
// reported one cycle later on issued_*. A command flagged "last" closes the
// block: the block waits for the allocator to drain all tags, then pulses
// block_done for one cycle.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only while IDLE)
//   cmd_reuse, cmd_bias_prev_sw, cmd_ddr_pe_sw, cmd_last   command fields
//   tag_req               request to the allocator (held until granted)
//   tag_reuse, tag_bias_prev_sw, tag_ddr_pe_sw             request qualifiers
//   tag_ready, tag        allocator grant and granted tag
//   tag_done              allocator reports all tags free
//   block_done            one-cycle end-of-block pulse
//   issued_valid/_tag/_reuse   one-cycle grant report; tag/reuse hold
//   issue_count           saturating count of grants in the current block
//   busy                  FSM is not IDLE
// -----------------------------------------------------------------------------
module tag_req_gen #(
    parameter int TAG_W = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_reuse,
    input  logic             cmd_bias_prev_sw,
    input  logic             cmd_ddr_pe_sw,
    input  logic             cmd_last,
    output logic             tag_req,
    output logic             tag_reuse,
    output logic             tag_bias_prev_sw,
    output logic             tag_ddr_pe_sw,
    input  logic             tag_ready,
    input  logic [TAG_W-1:0] tag,
    input  logic             tag_done,
    output logic             block_done,
    output logic             issued_valid,
    output logic [TAG_W-1:0] issued_tag,
    output logic             issued_reuse,
    output logic [CNT_W-1:0] issue_count,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_accept;
    logic               w_grant;

    logic               r_reuse;
    logic               r_bias;
    logic               r_ddr;
    logic               r_last;
    logic               r_have_prev;
    logic               r_issued_valid;
    logic [TAG_W-1:0]   r_issued_tag;
    logic               r_issued_reuse;
    logic [CNT_W-1:0]   r_count;

    assign w_accept = cmd_valid && cmd_ready;
    assign w_grant  = (r_state == S_REQ) && tag_ready;

    always_comb begin
        w_next           = r_state;
        cmd_ready        = 1'b0;
        tag_req          = 1'b0;
        tag_reuse        = 1'b0;
        tag_bias_prev_sw = 1'b0;
        tag_ddr_pe_sw    = 1'b0;
        block_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = !reset;
                if (w_accept) w_next = S_REQ;
            end
            S_REQ: begin
                tag_req          = 1'b1;
                tag_reuse        = r_reuse;
                tag_bias_prev_sw = r_bias;
                tag_ddr_pe_sw    = r_ddr;
                if (tag_ready) w_next = r_last ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                if (tag_done) w_next = S_DONE;
            end
            S_DONE: begin
                block_done = 1'b1;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_reuse        <= 1'b0;
            r_bias         <= 1'b0;
            r_ddr          <= 1'b0;
            r_last         <= 1'b0;
            r_have_prev    <= 1'b0;
            r_issued_valid <= 1'b0;
            r_issued_tag   <= '0;
            r_issued_reuse <= 1'b0;
            r_count        <= '0;
        end else begin
            r_issued_valid <= w_grant;
            if (w_accept) begin
                // Nothing to reuse yet in a fresh block: force reuse off.
                r_reuse <= cmd_reuse && r_have_prev;
                r_bias  <= cmd_bias_prev_sw;
                r_ddr   <= cmd_ddr_pe_sw;
                r_last  <= cmd_last;
            end
            if (w_grant) begin
                r_issued_tag   <= tag;
                r_issued_reuse <= r_reuse;
            end
            // DONE never coincides with a grant, so the two updates are exclusive.
            if (r_state == S_DONE) begin
                r_have_prev <= 1'b0;
                r_count     <= '0;
            end else if (w_grant) begin
                r_have_prev <= 1'b1;
                if (r_count != {CNT_W{1'b1}}) r_count <= r_count + 1'b1;
            end
        end
    end

    assign issued_valid = r_issued_valid;
    assign issued_tag   = r_issued_tag;
    assign issued_reuse = r_issued_reuse;
    assign issue_count  = r_count;
    assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_tag_req_gen.sv
module tb_tag_req_gen;
    localparam int TAG_W = 2;
    localparam int CNT_W = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_reuse = 1'b0, cmd_bias_prev_sw = 1'b0, cmd_ddr_pe_sw = 1'b0, cmd_last = 1'b0;
    logic             tag_req, tag_reuse, tag_bias_prev_sw, tag_ddr_pe_sw;
    logic             tag_ready = 1'b0;
    logic [TAG_W-1:0] tag = '0;
    logic             tag_done = 1'b0;
    logic             block_done, issued_valid, issued_reuse, busy;
    logic [TAG_W-1:0] issued_tag;
    logic [CNT_W-1:0] issue_count;

    tag_req_gen #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_reuse(cmd_reuse), .cmd_bias_prev_sw(cmd_bias_prev_sw),
        .cmd_ddr_pe_sw(cmd_ddr_pe_sw), .cmd_last(cmd_last),
        .tag_req(tag_req), .tag_reuse(tag_reuse),
        .tag_bias_prev_sw(tag_bias_prev_sw), .tag_ddr_pe_sw(tag_ddr_pe_sw),
        .tag_ready(tag_ready), .tag(tag), .tag_done(tag_done),
        .block_done(block_done), .issued_valid(issued_valid),
        .issued_tag(issued_tag), .issued_reuse(issued_reuse),
        .issue_count(issue_count), .busy(busy)
    );

    typedef struct {
        logic [TAG_W-1:0] tg;
        logic             reuse;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t q_iss[$];
    int   q_bd[$];
    exp_t mon_e;
    int   mon_c;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every issued_valid / block_done pulse consumes one expectation.
    always @(negedge clk) begin
        if (issued_valid === 1'b1) begin
            if (q_iss.size() == 0) chk("unexpected_issued_valid", 32'(issued_valid), 0);
            else begin
                mon_e = q_iss.pop_front();
                chk("issued_tag", 32'(issued_tag), 32'(mon_e.tg));
                chk("issued_reuse", 32'(issued_reuse), 32'(mon_e.reuse));
                chk("issue_count_at_issue", 32'(issue_count), 32'(mon_e.cnt));
            end
        end
        if (block_done === 1'b1) begin
            if (q_bd.size() == 0) chk("unexpected_block_done", 32'(block_done), 0);
            else begin
                mon_c = q_bd.pop_front();
                chk("issue_count_at_done", 32'(issue_count), 32'(mon_c));
            end
        end
    end

    task automatic chk_idle(input string tagname);
        chk({tagname, "_cmd_ready"}, 32'(cmd_ready), 1);
        chk({tagname, "_tag_req"}, 32'(tag_req), 0);
        chk({tagname, "_tag_reuse"}, 32'(tag_reuse), 0);
        chk({tagname, "_tag_bias"}, 32'(tag_bias_prev_sw), 0);
        chk({tagname, "_tag_ddr"}, 32'(tag_ddr_pe_sw), 0);
        chk({tagname, "_block_done"}, 32'(block_done), 0);
        chk({tagname, "_issued_valid"}, 32'(issued_valid), 0);
        chk({tagname, "_issued_tag"}, 32'(issued_tag), 0);
        chk({tagname, "_issued_reuse"}, 32'(issued_reuse), 0);
        chk({tagname, "_issue_count"}, 32'(issue_count), 0);
        chk({tagname, "_busy"}, 32'(busy), 0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_idle("after_reset");
    endtask

    // One command through to its grant. er = expected effective reuse,
    // ec = expected issue_count after the grant. Fields are flipped after
    // accept and cmd_valid is held during a stall to show neither is sampled.
    task automatic issue(input logic r, input logic b, input logic d, input logic l,
                         input logic er, input logic [TAG_W-1:0] tg,
                         input int stall, input logic [CNT_W-1:0] ec);
        cmd_valid = 1'b1; cmd_reuse = r; cmd_bias_prev_sw = b; cmd_ddr_pe_sw = d; cmd_last = l;
        chk("cmd_ready_before_accept", 32'(cmd_ready), 1);
        @(posedge clk); #1;
        cmd_reuse = ~r; cmd_bias_prev_sw = ~b; cmd_ddr_pe_sw = ~d; cmd_last = ~l;
        cmd_valid = (stall > 0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("tag_req_stall", 32'(tag_req), 1);
            chk("tag_reuse_stall", 32'(tag_reuse), 32'(er));
            chk("tag_bias_stall", 32'(tag_bias_prev_sw), 32'(b));
            chk("tag_ddr_stall", 32'(tag_ddr_pe_sw), 32'(d));
            chk("cmd_ready_stall", 32'(cmd_ready), 0);
            @(posedge clk); #1;
        end
        tag_ready = 1'b1; tag = tg;
        q_iss.push_back('{tg, er, ec});
        @(negedge clk);
        chk("tag_req_grant", 32'(tag_req), 1);
        chk("tag_reuse_grant", 32'(tag_reuse), 32'(er));
        chk("tag_bias_grant", 32'(tag_bias_prev_sw), 32'(b));
        chk("tag_ddr_grant", 32'(tag_ddr_pe_sw), 32'(d));
        @(posedge clk); #1;
        tag_ready = 1'b0; cmd_valid = 1'b0; tag = ~tg;
        @(negedge clk);
        chk("tag_req_after_grant", 32'(tag_req), 0);
        chk("tag_reuse_after_grant", 32'(tag_reuse), 0);
        chk("cmd_ready_after_grant", 32'(cmd_ready), 32'(!l));
        chk("busy_after_grant", 32'(busy), 32'(l));
        chk("issue_count_after_grant", 32'(issue_count), 32'(ec));
    endtask

    // Called in the first DRAIN cycle; tag_done rises after n DRAIN cycles.
    task automatic drain(input int n, input int ec);
        chk("block_done_drain0", 32'(block_done), 0);
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            chk("block_done_drain", 32'(block_done), 0);
            chk("busy_drain", 32'(busy), 1);
            chk("cmd_ready_drain", 32'(cmd_ready), 0);
        end
        tag_done = 1'b1;
        q_bd.push_back(ec);
        @(posedge clk); #1 tag_done = 1'b0;
        @(negedge clk);
        chk("block_done_pulse", 32'(block_done), 1);
        chk("cmd_ready_done", 32'(cmd_ready), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("block_done_cleared", 32'(block_done), 0);
        chk("issue_count_cleared", 32'(issue_count), 0);
        chk("cmd_ready_post_done", 32'(cmd_ready), 1);
        chk("busy_post_done", 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        chk("cmd_ready_in_reset", 32'(cmd_ready), 0);
        do_reset(3);

        // Stray grant / tag_done while idle do nothing.
        tag_ready = 1'b1; tag_done = 1'b1; tag = 2'd3;
        @(posedge clk); #1 tag_ready = 1'b0; tag_done = 1'b0;
        @(negedge clk);
        chk_idle("stray_inputs");

        // First command after reset has reuse forced off; second keeps it.
        issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 0, 2'd1);
        issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 0, 2'd2);

        // Basic grant, then 5-cycle backpressure.
        do_reset(1);
        issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 0, 2'd1);
        issue(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 5, 2'd2);

        // Block end: three commands, last one closes the block.
        do_reset(1);
        issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 0, 2'd1);
        issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1, 2'd2);
        issue(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 0, 2'd3);
        drain(4, 3);
        issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 0, 2'd1);

        // Saturation with a 2-bit counter: 1,2,3,3,3.
        do_reset(1);
        issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 0, 2'd1);
        issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 0, 2'd2);
        issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 0, 2'd3);
        issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 0, 2'd3);
        issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 0, 2'd3);

        // tag_done already high on the first DRAIN cycle.
        issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 0, 2'd3);
        drain(1, 3);

        // Reset while in REQ with a grant offered: grant ignored.
        cmd_valid = 1'b1; cmd_reuse = 1'b1; cmd_bias_prev_sw = 1'b1; cmd_ddr_pe_sw = 1'b1; cmd_last = 1'b1;
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("tag_req_before_reset", 32'(tag_req), 1);
        reset = 1'b1; tag_ready = 1'b1; tag = 2'd3;
        @(posedge clk); #1 reset = 1'b0; tag_ready = 1'b0;
        @(negedge clk);
        chk_idle("reset_in_req");
        @(negedge clk);
        chk_idle("reset_in_req_next");
        issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 0, 2'd1);

        // Reset while in DRAIN with tag_done offered: no block_done.
        issue(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1, 2'd2);
        reset = 1'b1; tag_done = 1'b1;
        @(posedge clk); #1 reset = 1'b0; tag_done = 1'b0;
        @(negedge clk);
        chk_idle("reset_in_drain");
        @(negedge clk);
        chk_idle("reset_in_drain_next");
        issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 0, 2'd1);

        repeat (3) @(negedge clk);
        chk("issue_queue_empty", 32'(q_iss.size()), 0);
        chk("done_queue_empty", 32'(q_bd.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tag_req_gen.md
TAG_REQ_GEN -- requirements
Module: tag_req_gen

Interface
REQ-001 Parameters: TAG_W, default 1, width of tag fields; CNT_W, default 8, width of issue_count.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 cmd_valid  input  1  a block command is offered.
REQ-005 cmd_ready  output  1  the block accepts a command this cycle.
REQ-006 cmd_reuse, cmd_bias_prev_sw, cmd_ddr_pe_sw, cmd_last  input  1 each  command fields: reuse the previous tag, bias switch, DDR/PE switch, last command of the block.
REQ-007 tag_req  output  1  tag request to the tag allocator.
REQ-008 tag_reuse, tag_bias_prev_sw, tag_ddr_pe_sw  output  1 each  request qualifiers.
REQ-009 tag_ready  input  1  the allocator can grant the request.
REQ-010 tag  input  TAG_W  tag granted by the allocator.
REQ-011 tag_done  input  1  all allocator tags are free.
REQ-012 block_done  output  1  one-cycle end-of-block pulse to the allocator.
REQ-013 issued_valid  output  1  one-cycle pulse: a tag was granted.
REQ-014 issued_tag  output  TAG_W  granted tag.
REQ-015 issued_reuse  output  1  effective reuse flag of the granted tag.
REQ-016 issue_count  output  CNT_W  grants since the last block_done.
REQ-017 busy  output  1  state is not IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, DRAIN and DONE.
REQ-019 cmd_ready SHALL be 1 only in IDLE while reset=0.
- Command accept: cmd_valid and cmd_ready in IDLE.
REQ-020 On command accept, the block SHALL latch all cmd_* fields and enter REQ.
REQ-021 In REQ, tag_req SHALL be 1 and the qualifier outputs SHALL drive the latched fields; outside REQ, tag_req, tag_reuse, tag_bias_prev_sw and tag_ddr_pe_sw SHALL be 0.
- Latency: a command accepted in cycle T has tag_req=1 in cycle T+1.
REQ-022 The request SHALL stay asserted with stable qualifiers until a grant, i.e. a cycle with tag_req=1 and tag_ready=1.
- No timeout.
REQ-023 In the grant cycle G, the block SHALL sample tag into issued_tag, latch the effective reuse flag into issued_reuse and assert issued_valid in cycle G+1 only.
- issued_tag and issued_reuse hold until the next grant.
REQ-024 After a grant, the FSM SHALL go to DRAIN if the latched last flag is 1, else to IDLE.
- Maximum throughput: one command per 2 cycles.
REQ-025 A have_prev flag SHALL be cleared by reset and by the block_done pulse, and set on every grant.
REQ-026 A command accepted with have_prev=0 SHALL have its reuse flag forced to 0.
- This covers the first command after reset and the first command after block_done; the allocator then sees tag_reuse=0.
REQ-027 In DRAIN, the FSM SHALL wait for tag_done=1 and then enter DONE.
- tag_done already 1 on the first DRAIN cycle: DRAIN still lasts exactly 1 cycle.
REQ-028 In DONE, block_done SHALL be 1 for exactly that one cycle, then the FSM SHALL return to IDLE.
- block_done is 0 in every other state.
REQ-029 issue_count SHALL increment by 1 on each grant and saturate at 2^CNT_W-1 without wrapping.
REQ-030 issue_count SHALL clear to 0 in the cycle after the DONE cycle.
- Clearing takes priority; a grant cannot coincide with DONE.
REQ-031 cmd_valid while not in IDLE SHALL be ignored and the command not consumed.
- Changes on cmd_* fields outside the accept cycle have no effect.
REQ-032 tag_ready or tag_done outside REQ and DRAIN respectively SHALL have no effect.

Reset
REQ-033 When reset=1 at a clock edge, the FSM SHALL go to IDLE from any state, including mid-REQ and mid-DRAIN, and discard any latched command.
REQ-034 After reset, every output SHALL be 0, except cmd_ready, which SHALL be 1 from the first cycle with reset=0.
- Outputs after reset: tag_req, qualifiers, block_done, issued_valid, issued_tag, issued_reuse, issue_count and busy are all 0.
REQ-035 A grant or tag_done coinciding with reset SHALL be ignored.

Verification
REQ-036 Basic grant: cmd(reuse=0, last=0) at T, tag_ready=1 at T+1, tag=1 -> tag_req=1 only at T+1; issued_valid=1 at T+2 with issued_tag=1; issue_count=1; cmd_ready=1 at T+2.
REQ-037 Backpressure: tag_ready held 0 for 5 cycles after accept -> tag_req held 1 for 6 cycles with stable qualifiers; cmd_valid during the stall is not accepted.
REQ-038 First-command reuse: cmd(reuse=1) right after reset -> tag_reuse=0 during REQ and issued_reuse=0; a second cmd(reuse=1) -> tag_reuse=1 and issued_reuse=1.
REQ-039 Block end: 3 commands, the third with last=1, tag_done=0 for 4 cycles after the third grant, then 1 -> a single block_done pulse 1 cycle after tag_done; issue_count goes 3->0; the next cmd(reuse=1) is forced to reuse=0.
REQ-040 Saturation: CNT_W=2, 5 grants without last -> issue_count sequence 1,2,3,3,3.
REQ-041 Reset mid-operation: reset asserted in REQ and in DRAIN -> next cycle in IDLE with all outputs 0, no issued_valid, no block_done; normal operation resumes.
